spi_3wire_arbiter: RTL and testbench
====================================

// Module: spi_3wire_arbiter
// PURPOSE
// Round-robin arbiter sharing one spi_3wire_controller among NUM_CLIENTS requesters
// (e.g. display refresh, keypad poll, config writer). Registers the granted client's
// transaction onto the controller inputs and drives the activate/busy handshake.
// Returns read bytes to the client with a one-cycle ack, plus an error flag for
// rejected or timed-out requests.
// PARAMETERS
// NUM_CLIENTS     3    number of requesters, >=2
// NUM_SELECTS     2    chip-select width; must match the controller
// OUT_BYTES       8    max bytes written per transaction; must match the controller
// IN_BYTES        4    max bytes read per transaction; must match the controller
// OUT_BYTES_SZ    $clog2(OUT_BYTES+1)    width of out_count
// IN_BYTES_SZ     $clog2(IN_BYTES+1)     width of in_count
// LAUNCH_TIMEOUT  64   cycles to wait for spi_busy to rise; must be > CLK_DIV/2+1
// PORTS
// clk           in   1                           system clock
// reset         in   1                           synchronous, active-high
// c_req         in   NUM_CLIENTS                 per-client request; hold high until c_ack
// c_cs          in   [NUM_CLIENTS][NUM_SELECTS]  active-high chip selects per client
// c_out_data    in   [NUM_CLIENTS][OUT_BYTES][8] write bytes per client
// c_out_count   in   [NUM_CLIENTS][OUT_BYTES_SZ] bytes to write
// c_in_count    in   [NUM_CLIENTS][IN_BYTES_SZ]  bytes to read
// c_grant       out  NUM_CLIENTS                 one-hot; owner of the current transaction
// c_ack         out  NUM_CLIENTS                 one-cycle completion pulse to the owner
// c_err         out  1                           valid with c_ack; 1 = rejected or timed out
// rsp_in_data   out  [IN_BYTES][8]               read bytes; valid from c_ack until the next ack
// spi_busy      in   1                           controller busy
// spi_activate  out  1                           controller activate
// spi_in_cs, spi_out_data, spi_out_count, spi_in_count  out  ctrl widths  registered copies of the owner's request
// spi_in_data   in   [IN_BYTES][8]               controller read data
// BEHAVIOUR
// Reset: all outputs 0; state = S_IDLE; RR pointer = NUM_CLIENTS-1, so client 0 has top priority.
// S_IDLE: grant only when some c_req=1 AND spi_busy=0.
// - Winner is the first requester searching from last_grant+1, with wrap-around.
// - At the grant edge: c_grant<=onehot(winner), last_grant<=winner; latch cs/data/counts into spi_* regs.
// - Client may change its operands after c_grant rises.
// - Invalid request (cs==0, out_count==0, out_count>OUT_BYTES or in_count>IN_BYTES) -> S_REJECT.
//   No spi_activate is issued.
// - Valid request -> S_LAUNCH with spi_activate<=1 and timeout counter<=LAUNCH_TIMEOUT-1.
// S_LAUNCH: hold spi_activate until spi_busy=1 is sampled, then spi_activate<=0 -> S_WAIT.
// - The controller samples activate only on half-bit ticks, hence the hold.
// - Counter reaches 0 with busy still 0: spi_activate<=0, err<=1 -> S_COMPLETE.
// S_WAIT: when spi_busy=0 is sampled -> S_COMPLETE with err<=0.
// S_REJECT: err<=1 -> S_COMPLETE.
// S_COMPLETE (1 cycle): c_ack=c_grant; c_err=err; c_grant<=0 -> S_IDLE.
// - Latch rsp_in_data<=spi_in_data only when err=0; otherwise rsp_in_data is unchanged.
// Latency (valid request, controller idle):
// - c_req seen at cycle 0 -> c_grant and spi_activate high at cycle 1.
// - c_ack is 2 cycles after the first spi_busy=0 sample in S_WAIT.
// Rejected request: c_req at cycle 0 -> c_grant at 1 -> c_ack+c_err at 3.
// Client drops c_req mid-transaction: ignored; the transaction completes and c_ack still pulses.
// c_req still high after c_ack: client stays eligible, but the RR pointer gives the other clients priority first.
// One transaction at a time; minimum 1 S_IDLE cycle between transactions; c_ack and c_grant are never both high for different clients.
// Reset mid-operation: returns to reset values, no c_ack issued; S_IDLE then waits for spi_busy=0 (the controller reports busy during its own reset).
// TESTING
// T1 client0 req, cs=01, out_count=2, data {0x40,0xC0}, in_count=0, real controller CLK_DIV=4
//    -> grant=001 at cycle 1; activate held until busy; ack=001, err=0; bytes 0x40,0xC0 on dio.
// T2 all three req held continuously -> grant order 0,1,2,0,1; exactly one ack per grant.
// T3 client1 out_count=0 -> grant=010 at cycle 1, ack=010 with err=1 at cycle 3; spi_activate never high.
// T4 busy model stuck at 0 -> activate high for exactly LAUNCH_TIMEOUT cycles, then ack with err=1.
// T5 client2 read: out_count=1, in_count=2; model returns 0xA5,0x3C -> rsp_in_data[0]=0xA5, [1]=0x3C at ack.
// T6 reset in S_WAIT with busy=1 -> all outputs 0 next cycle; no grant until busy=0, then client0 wins.

Source files
------------

// File: rtl/spi_3wire_arbiter_if.sv
// ---------------------------------------------------------------------------
// spi_3wire_arbiter_if
// Bundles the client request/response signals and the spi_3wire_controller
// command/status signals that the round-robin arbiter sits between.
//
// Client side : c_req, c_cs, c_out_data, c_out_count, c_in_count (to arbiter)
//               c_grant, c_ack, c_err, rsp_in_data            (from arbiter)
// SPI side    : spi_busy, spi_in_data                          (to arbiter)
//               spi_activate, spi_in_cs, spi_out_data,
//               spi_out_count, spi_in_count                   (from arbiter)
//
// Modports: slave  = arbiter view
//           master = clients + controller view
// ---------------------------------------------------------------------------
interface spi_3wire_arbiter_if #(
    parameter int NUM_CLIENTS  = 3,
    parameter int NUM_SELECTS  = 2,
    parameter int OUT_BYTES    = 8,
    parameter int IN_BYTES     = 4,
    parameter int OUT_BYTES_SZ = $clog2(OUT_BYTES + 1),
    parameter int IN_BYTES_SZ  = $clog2(IN_BYTES + 1)
);
    logic [NUM_CLIENTS-1:0]                      c_req;
    logic [NUM_CLIENTS-1:0][NUM_SELECTS-1:0]     c_cs;
    logic [NUM_CLIENTS-1:0][OUT_BYTES-1:0][7:0]  c_out_data;
    logic [NUM_CLIENTS-1:0][OUT_BYTES_SZ-1:0]    c_out_count;
    logic [NUM_CLIENTS-1:0][IN_BYTES_SZ-1:0]     c_in_count;
    logic [NUM_CLIENTS-1:0]                      c_grant;
    logic [NUM_CLIENTS-1:0]                      c_ack;
    logic                                        c_err;
    logic [IN_BYTES-1:0][7:0]                    rsp_in_data;

    logic                                        spi_busy;
    logic                                        spi_activate;
    logic [NUM_SELECTS-1:0]                      spi_in_cs;
    logic [OUT_BYTES-1:0][7:0]                   spi_out_data;
    logic [OUT_BYTES_SZ-1:0]                     spi_out_count;
    logic [IN_BYTES_SZ-1:0]                      spi_in_count;
    logic [IN_BYTES-1:0][7:0]                    spi_in_data;

    modport slave (
        input  c_req, c_cs, c_out_data, c_out_count, c_in_count,
        input  spi_busy, spi_in_data,
        output c_grant, c_ack, c_err, rsp_in_data,
        output spi_activate, spi_in_cs, spi_out_data, spi_out_count, spi_in_count
    );

    modport master (
        output c_req, c_cs, c_out_data, c_out_count, c_in_count,
        output spi_busy, spi_in_data,
        input  c_grant, c_ack, c_err, rsp_in_data,
        input  spi_activate, spi_in_cs, spi_out_data, spi_out_count, spi_in_count
    );
endinterface

// File: rtl/spi_3wire_arbiter.sv
// ---------------------------------------------------------------------------
// spi_3wire_arbiter
// Round-robin arbiter sharing one spi_3wire_controller among NUM_CLIENTS
// requesters. The winner's chip-select, write bytes and counts are registered
// onto the controller inputs, activate is held until the controller reports
// busy, and completion is returned to the owner as a one-cycle c_ack with
// c_err (rejected request or launch timeout) and the read bytes.
//
// Ports
//   clk    : system clock
//   reset  : synchronous, active-high
//   bus    : spi_3wire_arbiter_if.slave (client request/response + controller)
// ---------------------------------------------------------------------------
module spi_3wire_arbiter #(
    parameter int NUM_CLIENTS    = 3,
    parameter int NUM_SELECTS    = 2,
    parameter int OUT_BYTES      = 8,
    parameter int IN_BYTES       = 4,
    parameter int OUT_BYTES_SZ   = $clog2(OUT_BYTES + 1),
    parameter int IN_BYTES_SZ    = $clog2(IN_BYTES + 1),
    parameter int LAUNCH_TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                reset,
    spi_3wire_arbiter_if.slave  bus
);
    localparam int PTR_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
    localparam int TMO_W = (LAUNCH_TIMEOUT > 1) ? $clog2(LAUNCH_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0]        TMO_INIT = TMO_W'(LAUNCH_TIMEOUT - 1);
    localparam logic [OUT_BYTES_SZ-1:0] OUT_MAX  = OUT_BYTES_SZ'(OUT_BYTES);
    localparam logic [IN_BYTES_SZ-1:0]  IN_MAX   = IN_BYTES_SZ'(IN_BYTES);

    typedef enum logic [2:0] {
        S_IDLE, S_LAUNCH, S_WAIT, S_REJECT, S_COMPLETE
    } state_t;

    state_t                      state, state_nxt;
    logic [PTR_W-1:0]            last_grant, last_grant_nxt;
    logic [TMO_W-1:0]            tmo, tmo_nxt;
    logic                        err, err_nxt;
    logic [NUM_CLIENTS-1:0]      grant_q, grant_nxt;
    logic [NUM_CLIENTS-1:0]      ack_q, ack_nxt;
    logic                        cerr_q, cerr_nxt;
    logic                        act_q, act_nxt;
    logic                        latch_req, latch_rsp;

    logic [NUM_SELECTS-1:0]      cs_q;
    logic [OUT_BYTES-1:0][7:0]   odata_q;
    logic [OUT_BYTES_SZ-1:0]     ocnt_q;
    logic [IN_BYTES_SZ-1:0]      icnt_q;
    logic [IN_BYTES-1:0][7:0]    rsp_q;

    logic                        found;
    logic [PTR_W-1:0]            win;
    logic                        win_valid;
    int                          idx;

    // Round-robin search starting just after the last owner, with wrap-around.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int i = 1; i <= NUM_CLIENTS; i++) begin
            idx = int'(last_grant) + i;
            if (idx >= NUM_CLIENTS) idx = idx - NUM_CLIENTS;
            if (!found && bus.c_req[PTR_W'(idx)]) begin
                found = 1'b1;
                win   = PTR_W'(idx);
            end
        end
        win_valid = (bus.c_cs[win] != '0) &&
                    (bus.c_out_count[win] != '0) &&
                    (bus.c_out_count[win] <= OUT_MAX) &&
                    (bus.c_in_count[win] <= IN_MAX);
    end

    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        tmo_nxt        = tmo;
        err_nxt        = err;
        grant_nxt      = grant_q;
        ack_nxt        = '0;
        cerr_nxt       = 1'b0;
        act_nxt        = act_q;
        latch_req      = 1'b0;
        latch_rsp      = 1'b0;
        case (state)
            // The controller reports busy during its own reset, so an idle
            // controller is required before anything is granted.
            S_IDLE: begin
                if (found && !bus.spi_busy) begin
                    grant_nxt      = NUM_CLIENTS'(1) << win;
                    last_grant_nxt = win;
                    latch_req      = 1'b1;
                    if (win_valid) begin
                        act_nxt   = 1'b1;
                        tmo_nxt   = TMO_INIT;
                        state_nxt = S_LAUNCH;
                    end else begin
                        state_nxt = S_REJECT;
                    end
                end
            end
            // Activate is only sampled on controller half-bit ticks, so it is
            // held until busy is seen or the launch window expires.
            S_LAUNCH: begin
                if (bus.spi_busy) begin
                    act_nxt   = 1'b0;
                    state_nxt = S_WAIT;
                end else if (tmo == '0) begin
                    act_nxt   = 1'b0;
                    err_nxt   = 1'b1;
                    state_nxt = S_COMPLETE;
                end else begin
                    tmo_nxt = tmo - TMO_W'(1);
                end
            end
            S_WAIT: begin
                if (!bus.spi_busy) begin
                    err_nxt   = 1'b0;
                    state_nxt = S_COMPLETE;
                end
            end
            S_REJECT: begin
                err_nxt   = 1'b1;
                state_nxt = S_COMPLETE;
            end
            S_COMPLETE: begin
                ack_nxt   = grant_q;
                cerr_nxt  = err;
                grant_nxt = '0;
                latch_rsp = !err;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            last_grant <= PTR_W'(NUM_CLIENTS - 1);
            tmo        <= '0;
            err        <= 1'b0;
            grant_q    <= '0;
            ack_q      <= '0;
            cerr_q     <= 1'b0;
            act_q      <= 1'b0;
            cs_q       <= '0;
            odata_q    <= '0;
            ocnt_q     <= '0;
            icnt_q     <= '0;
            rsp_q      <= '0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            tmo        <= tmo_nxt;
            err        <= err_nxt;
            grant_q    <= grant_nxt;
            ack_q      <= ack_nxt;
            cerr_q     <= cerr_nxt;
            act_q      <= act_nxt;
            if (latch_req) begin
                cs_q    <= bus.c_cs[win];
                odata_q <= bus.c_out_data[win];
                ocnt_q  <= bus.c_out_count[win];
                icnt_q  <= bus.c_in_count[win];
            end
            if (latch_rsp) rsp_q <= bus.spi_in_data;
        end
    end

    assign bus.c_grant       = grant_q;
    assign bus.c_ack         = ack_q;
    assign bus.c_err         = cerr_q;
    assign bus.rsp_in_data   = rsp_q;
    assign bus.spi_activate  = act_q;
    assign bus.spi_in_cs     = cs_q;
    assign bus.spi_out_data  = odata_q;
    assign bus.spi_out_count = ocnt_q;
    assign bus.spi_in_count  = icnt_q;
endmodule

// File: tb/tb_spi_3wire_arbiter.sv
// ---------------------------------------------------------------------------
// tb_spi_3wire_arbiter
// Directed bench for spi_3wire_arbiter with a hand-driven controller busy
// line. Inputs change 1 time unit after each rising edge; outputs are read at
// the same point, i.e. after the edge that produced them.
// ---------------------------------------------------------------------------
module tb_spi_3wire_arbiter;
    localparam int NC  = 3;
    localparam int NS  = 2;
    localparam int OB  = 8;
    localparam int IB  = 4;
    localparam int OBS = $clog2(OB + 1);
    localparam int IBS = $clog2(IB + 1);
    localparam int LT  = 16;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   cnt;

    always #5 clk = ~clk;

    spi_3wire_arbiter_if #(
        .NUM_CLIENTS(NC), .NUM_SELECTS(NS), .OUT_BYTES(OB), .IN_BYTES(IB),
        .OUT_BYTES_SZ(OBS), .IN_BYTES_SZ(IBS)
    ) bus ();

    spi_3wire_arbiter #(
        .NUM_CLIENTS(NC), .NUM_SELECTS(NS), .OUT_BYTES(OB), .IN_BYTES(IB),
        .OUT_BYTES_SZ(OBS), .IN_BYTES_SZ(IBS), .LAUNCH_TIMEOUT(LT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_client(input int i, input logic [NS-1:0] cs, input logic [OBS-1:0] oc,
                              input logic [IBS-1:0] ic, input logic [63:0] data);
        bus.c_cs[i]        = cs;
        bus.c_out_count[i] = oc;
        bus.c_in_count[i]  = ic;
        bus.c_out_data[i]  = data;
    endtask

    // Valid transaction: grant + activate, busy for one cycle, then ack.
    task automatic do_txn(input string tag, input logic [NC-1:0] exp);
        tick();
        check({tag, "_grant"}, 64'(bus.c_grant), 64'(exp));
        check({tag, "_act_on"}, 64'(bus.spi_activate), 64'd1);
        bus.spi_busy = 1'b1;
        tick();
        check({tag, "_act_off"}, 64'(bus.spi_activate), 64'd0);
        bus.spi_busy = 1'b0;
        tick();
        check({tag, "_no_early_ack"}, 64'(bus.c_ack), 64'd0);
        tick();
        check({tag, "_ack"}, 64'(bus.c_ack), 64'(exp));
        check({tag, "_err"}, 64'(bus.c_err), 64'd0);
        check({tag, "_grant_clr"}, 64'(bus.c_grant), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset            = 1'b1;
        bus.c_req        = '0;
        bus.c_cs         = '0;
        bus.c_out_data   = '0;
        bus.c_out_count  = '0;
        bus.c_in_count   = '0;
        bus.spi_busy     = 1'b0;
        bus.spi_in_data  = '0;
        tick();
        tick();
        check("rst_grant", 64'(bus.c_grant), 64'd0);
        check("rst_ack", 64'(bus.c_ack), 64'd0);
        check("rst_err", 64'(bus.c_err), 64'd0);
        check("rst_act", 64'(bus.spi_activate), 64'd0);
        check("rst_ocnt", 64'(bus.spi_out_count), 64'd0);
        check("rst_rsp", 64'(bus.rsp_in_data), 64'd0);
        reset = 1'b0;

        // T1: client0 writes 0x40,0xC0; activate held two extra cycles.
        set_client(0, 2'b01, 4'd2, 3'd0, 64'h0000_0000_0000_C040);
        bus.c_req = 3'b001;
        tick();
        check("t1_grant", 64'(bus.c_grant), 64'h1);
        check("t1_act", 64'(bus.spi_activate), 64'd1);
        check("t1_cs", 64'(bus.spi_in_cs), 64'h1);
        check("t1_data", 64'(bus.spi_out_data), 64'h0000_0000_0000_C040);
        set_client(0, 2'b00, 4'd0, 3'd0, 64'hFFFF);
        tick();
        check("t1_act_hold1", 64'(bus.spi_activate), 64'd1);
        check("t1_ocnt_kept", 64'(bus.spi_out_count), 64'd2);
        tick();
        check("t1_act_hold2", 64'(bus.spi_activate), 64'd1);
        bus.spi_busy = 1'b1;
        tick();
        check("t1_act_drop", 64'(bus.spi_activate), 64'd0);
        bus.c_req = 3'b000;
        tick();
        tick();
        check("t1_busy_noack", 64'(bus.c_ack), 64'd0);
        check("t1_busy_grant", 64'(bus.c_grant), 64'h1);
        bus.spi_busy = 1'b0;
        tick();
        check("t1_wait_noack", 64'(bus.c_ack), 64'd0);
        tick();
        check("t1_ack", 64'(bus.c_ack), 64'h1);
        check("t1_err", 64'(bus.c_err), 64'd0);
        tick();
        check("t1_ack_pulse", 64'(bus.c_ack), 64'd0);

        // T2: all three request continuously from a fresh pointer.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_client(0, 2'b01, 4'd1, 3'd0, 64'h11);
        set_client(1, 2'b10, 4'd3, 3'd1, 64'h22);
        set_client(2, 2'b11, 4'd8, 3'd4, 64'h33);
        bus.c_req = 3'b111;
        do_txn("t2_0", 3'b001);
        do_txn("t2_1", 3'b010);
        do_txn("t2_2", 3'b100);
        do_txn("t2_3", 3'b001);
        do_txn("t2_4", 3'b010);
        bus.c_req = 3'b000;
        tick();
        check("t2_idle_grant", 64'(bus.c_grant), 64'd0);

        // T5: client2 reads two bytes.
        set_client(2, 2'b10, 4'd1, 3'd2, 64'h99);
        bus.spi_in_data = 32'h0000_3CA5;
        bus.c_req = 3'b100;
        do_txn("t5", 3'b100);
        check("t5_icnt", 64'(bus.spi_in_count), 64'd2);
        check("t5_rsp", 64'(bus.rsp_in_data), 64'h3CA5);
        bus.c_req = 3'b000;
        bus.spi_in_data = 32'hDEAD_BEEF;
        tick();

        // T3: client1 out_count=0 is rejected without activate.
        set_client(1, 2'b01, 4'd0, 3'd0, 64'h0);
        bus.c_req = 3'b010;
        tick();
        check("t3_grant", 64'(bus.c_grant), 64'h2);
        check("t3_act1", 64'(bus.spi_activate), 64'd0);
        tick();
        check("t3_act2", 64'(bus.spi_activate), 64'd0);
        check("t3_noack", 64'(bus.c_ack), 64'd0);
        tick();
        check("t3_ack", 64'(bus.c_ack), 64'h2);
        check("t3_err", 64'(bus.c_err), 64'd1);
        check("t3_act3", 64'(bus.spi_activate), 64'd0);
        check("t3_rsp_kept", 64'(bus.rsp_in_data), 64'h3CA5);
        bus.c_req = 3'b000;
        tick();

        // T3b: in_count above IN_BYTES is rejected too.
        set_client(0, 2'b01, 4'd1, 3'd5, 64'h0);
        bus.c_req = 3'b001;
        tick();
        check("t3b_grant", 64'(bus.c_grant), 64'h1);
        tick();
        tick();
        check("t3b_ack", 64'(bus.c_ack), 64'h1);
        check("t3b_err", 64'(bus.c_err), 64'd1);
        bus.c_req = 3'b000;
        tick();

        // T4: busy never rises; activate lasts exactly LT cycles.
        set_client(0, 2'b01, 4'd1, 3'd0, 64'h5A);
        bus.c_req = 3'b001;
        tick();
        check("t4_grant", 64'(bus.c_grant), 64'h1);
        cnt = 0;
        while (bus.spi_activate === 1'b1 && cnt < 100) begin
            cnt++;
            tick();
        end
        check("t4_act_cycles", 64'(cnt), 64'(LT));
        check("t4_noack", 64'(bus.c_ack), 64'd0);
        tick();
        check("t4_ack", 64'(bus.c_ack), 64'h1);
        check("t4_err", 64'(bus.c_err), 64'd1);
        check("t4_rsp_kept", 64'(bus.rsp_in_data), 64'h3CA5);
        bus.c_req = 3'b000;
        tick();

        // T6: reset while waiting on a busy controller.
        set_client(1, 2'b01, 4'd1, 3'd0, 64'h77);
        bus.c_req = 3'b010;
        tick();
        check("t6_grant", 64'(bus.c_grant), 64'h2);
        bus.spi_busy = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("t6_rst_grant", 64'(bus.c_grant), 64'd0);
        check("t6_rst_ack", 64'(bus.c_ack), 64'd0);
        check("t6_rst_act", 64'(bus.spi_activate), 64'd0);
        check("t6_rst_ocnt", 64'(bus.spi_out_count), 64'd0);
        check("t6_rst_rsp", 64'(bus.rsp_in_data), 64'd0);
        reset = 1'b0;
        set_client(0, 2'b10, 4'd2, 3'd1, 64'h1234);
        bus.c_req = 3'b011;
        tick();
        check("t6_busy_nogrant1", 64'(bus.c_grant), 64'd0);
        check("t6_busy_noack", 64'(bus.c_ack), 64'd0);
        tick();
        check("t6_busy_nogrant2", 64'(bus.c_grant), 64'd0);
        bus.spi_busy = 1'b0;
        tick();
        check("t6_grant0", 64'(bus.c_grant), 64'h1);
        check("t6_act", 64'(bus.spi_activate), 64'd1);
        check("t6_cs", 64'(bus.spi_in_cs), 64'h2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
